// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - reset synchroniser, stretch timer and staggered per-channel reset release
module rst_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int NUM_CH         = 3,
    parameter int CH_GAP         = 4
) (
    input  logic              clk,
    input  logic              RST_n,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_n_ch,
    output logic              rst_done,
    output logic              last_sw_rst
);

    localparam int CNT_MAX = (STRETCH_CYCLES > CH_GAP) ? STRETCH_CYCLES : CH_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {HOLD, STRETCH, SEQ, RUN} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_CH-1:0]      ch_q, ch_d;
    logic                   done_q, done_d;
    logic                   last_sw_q, last_sw_d;

    logic              sync_rise;
    logic [NUM_CH-1:0] ch_next;
    logic              last_rel;
    logic              stretch_end;
    logic              gap_end;
    logic              sw_take;

    // HOLD leaves on the edge where the chain output itself rises, so channel 0
    // can release at edge SYNC_STAGES + STRETCH_CYCLES.
    assign sync_rise   = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign ch_next     = (ch_q << 1) | NUM_CH'(1);
    assign last_rel    = ch_next[NUM_CH-1];
    assign stretch_end = (int'(cnt_q) == STRETCH_CYCLES);
    assign gap_end     = (int'(cnt_q) == CH_GAP - 1);
    assign sw_take     = sw_rst_req && (state_q != HOLD);

    always_ff @(negedge clk or negedge RST_n) begin
        if (!RST_n) begin
            sync_q    <= '0;
            state_q   <= HOLD;
            cnt_q     <= '0;
            ch_q      <= '0;
            done_q    <= 1'b0;
            last_sw_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            done_q    <= done_d;
            last_sw_q <= last_sw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD: begin
                if (sync_rise) begin
                    if (STRETCH_CYCLES == 0) state_d = last_rel ? RUN : SEQ;
                    else                     state_d = STRETCH;
                end
            end
            STRETCH: if (stretch_end)         state_d = last_rel ? RUN : SEQ;
            SEQ:     if (gap_end && last_rel) state_d = RUN;
            default: state_d = state_q;
        endcase
        if (sw_take) state_d = STRETCH;
    end

    // A software restart enters STRETCH with the counter at 0 while the
    // pushbutton path pre-counts its entry edge, giving the extra cycle of hold.
    always_comb begin
        cnt_d     = cnt_q + CW'(1);
        ch_d      = ch_q;
        last_sw_d = last_sw_q;
        done_d    = (state_q == RUN) && (state_d == RUN);
        case (state_q)
            HOLD: begin
                cnt_d = '0;
                if (sync_rise) begin
                    if (STRETCH_CYCLES == 0) ch_d  = ch_next;
                    else                     cnt_d = CW'(1);
                end
            end
            STRETCH: begin
                if (stretch_end) begin
                    cnt_d = '0;
                    ch_d  = ch_next;
                end
            end
            SEQ: begin
                if (gap_end) begin
                    cnt_d = '0;
                    ch_d  = ch_next;
                end
            end
            default: cnt_d = '0;
        endcase
        if (sw_take) begin
            cnt_d     = '0;
            ch_d      = '0;
            last_sw_d = 1'b1;
        end
    end

    assign rst_n_ch    = ch_q;
    assign rst_done    = done_q;
    assign last_sw_rst = last_sw_q;

endmodule
